// File: rtl/req_source.sv
// rtl/req_source.sv - switch-driven request generator with debounce, pending queue and periodic tick
//
// Purpose:
//   Turns a raw slide-switch level into clean press events, queues them in a
//   saturating pending counter, and produces a periodic one-cycle clock-enable
//   tick. While the downstream buffer is ready, it consumes one queued request
//   on each tick.
//
// Ports:
//   clk        in   system clock (CLOCK_50)
//   rst        in   synchronous active-low reset
//   sw_in      in   raw asynchronous switch level
//   req_ready  in   downstream can accept a request (looked at on tick cycles only)
//   tick       out  one-cycle pulse every TICK_DIV cycles
//   req_valid  out  at least one request pending
//   pend_count out  number of queued requests (3 bits)
//   overflow   out  sticky: a press was dropped while saturated
module req_source #(
    parameter int TICK_DIV = 50000000,
    parameter int DEBOUNCE = 500000,
    parameter int PEND_MAX = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_in,
    input  logic       req_ready,
    output logic       tick,
    output logic       req_valid,
    output logic [2:0] pend_count,
    output logic       overflow
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
    localparam logic [2:0]    PMAX      = 3'(PEND_MAX);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          lvl_q, lvl_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [2:0]    pend_q, pend_d;
    logic          ovf_q, ovf_d;

    logic tick_w;
    logic press;
    logic consume;

    always_comb begin
        s1_d = sw_in;
        s2_d = s1_q;

        // Only s2 feeds the debouncer; a new level is accepted after
        // DEBOUNCE consecutive cycles of disagreement with lvl.
        lvl_d  = lvl_q;
        dcnt_d = dcnt_q;
        if (s2_q == lvl_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DB_LAST) begin
            lvl_d  = s2_q;
            dcnt_d = '0;
        end else begin
            dcnt_d = dcnt_q + DW'(1);
        end

        // Rising acceptances only; releases never generate an event.
        press = (s2_q != lvl_q) && (dcnt_q == DB_LAST) && s2_q;

        tick_w = (tcnt_q == TICK_LAST);
        tcnt_d = tick_w ? '0 : tcnt_q + TW'(1);

        consume = tick_w && (pend_q != 3'd0) && req_ready;

        // A press coinciding with a consume cancels out, even when saturated,
        // so no press is lost in that case.
        pend_d = pend_q;
        ovf_d  = ovf_q;
        case ({press, consume})
            2'b10: begin
                if (pend_q == PMAX) ovf_d = 1'b1;
                else                pend_d = pend_q + 3'd1;
            end
            2'b01:   pend_d = pend_q - 3'd1;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            lvl_q  <= 1'b0;
            dcnt_q <= '0;
            tcnt_q <= '0;
            pend_q <= 3'd0;
            ovf_q  <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
            dcnt_q <= dcnt_d;
            tcnt_q <= tcnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign tick       = tick_w;
    assign req_valid  = (pend_q != 3'd0);
    assign pend_count = pend_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_req_source.sv
// tb/tb_req_source.sv - directed self-checking bench for req_source
module tb_req_source;

    logic       clk;
    logic       rst;
    logic       sw_in;
    logic       req_ready;
    logic       tick;
    logic       req_valid;
    logic [2:0] pend_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    req_source #(
        .TICK_DIV(8),
        .DEBOUNCE(4),
        .PEND_MAX(7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_in     (sw_in),
        .req_ready (req_ready),
        .tick      (tick),
        .req_valid (req_valid),
        .pend_count(pend_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; cyc counts edges since the last reset edge, so the
    // tick is expected exactly when cyc mod 8 == 7.
    task automatic step();
        @(posedge clk);
        if (!rst) cyc = 0;
        else      cyc = cyc + 1;
        #1;
        chk("tick_period", {31'd0, tick}, {31'd0, ((cyc % 8) == 7)});
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press_once();
        sw_in = 1'b1;
        steps(10);
        sw_in = 1'b0;
        steps(10);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_pend", {29'd0, pend_count}, 32'd0);
        chk("rst_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        sw_in     = 1'b0;
        req_ready = 1'b0;

        // 1: reset for two edges, then tick cadence (checked on every step)
        steps(2);
        rst = 1'b1;
        chk("init_pend", {29'd0, pend_count}, 32'd0);
        chk("init_valid", {31'd0, req_valid}, 32'd0);
        chk("init_ovf", {31'd0, overflow}, 32'd0);
        chk("init_tick", {31'd0, tick}, 32'd0);
        steps(7);
        chk("first_tick", {31'd0, tick}, 32'd1);
        steps(1);
        chk("tick_width", {31'd0, tick}, 32'd0);
        steps(7);
        chk("second_tick", {31'd0, tick}, 32'd1);

        // 2: held press accepted on the 6th edge after sw_in rises
        sw_in = 1'b1;
        steps(5);
        chk("press_early", {29'd0, pend_count}, 32'd0);
        steps(1);
        chk("press_cnt", {29'd0, pend_count}, 32'd1);
        chk("press_valid", {31'd0, req_valid}, 32'd1);
        steps(12);
        chk("press_hold", {29'd0, pend_count}, 32'd1);
        sw_in = 1'b0;
        steps(10);
        chk("release_noevt", {29'd0, pend_count}, 32'd1);

        // 3: 3-cycle glitch rejected
        do_reset();
        sw_in = 1'b1;
        steps(3);
        sw_in = 1'b0;
        steps(12);
        chk("glitch_pend", {29'd0, pend_count}, 32'd0);
        chk("glitch_valid", {31'd0, req_valid}, 32'd0);

        // 4: eight presses saturate at 7, eighth sets sticky overflow
        for (int i = 1; i <= 8; i++) begin
            press_once();
            chk("sat_pend", {29'd0, pend_count}, (i > 7) ? 32'd7 : 32'(i));
            chk("sat_ovf", {31'd0, overflow}, (i == 8) ? 32'd1 : 32'd0);
        end
        steps(20);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("sat_hold", {29'd0, pend_count}, 32'd7);

        // 5: three queued requests drained one per tick
        do_reset();
        for (int i = 0; i < 3; i++) press_once();
        chk("drain_start", {29'd0, pend_count}, 32'd3);
        req_ready = 1'b1;
        for (int p = 3; p >= 0; p--) begin
            for (int w = 0; w < 16 && (cyc % 8) != 7; w++) step();
            chk("drain_at_tick", {31'd0, tick}, 32'd1);
            chk("drain_before", {29'd0, pend_count}, 32'(p));
            step();
            chk("drain_after", {29'd0, pend_count}, (p > 0) ? 32'(p - 1) : 32'd0);
            chk("drain_valid", {31'd0, req_valid}, (p > 1) ? 32'd1 : 32'd0);
        end
        req_ready = 1'b0;

        // 6: press accepted on a consuming tick while saturated
        for (int i = 0; i < 7; i++) press_once();
        chk("fill7", {29'd0, pend_count}, 32'd7);
        for (int w = 0; w < 16 && (cyc % 8) != 2; w++) step();
        sw_in     = 1'b1;
        req_ready = 1'b1;
        steps(5);
        chk("align_tick", {31'd0, tick}, 32'd1);
        steps(1);
        chk("align_pend", {29'd0, pend_count}, 32'd7);
        chk("align_ovf", {31'd0, overflow}, 32'd0);
        req_ready = 1'b0;
        sw_in     = 1'b0;
        steps(10);
        chk("align_settle", {29'd0, pend_count}, 32'd7);

        // reset in the middle of a debounce discards the press
        sw_in = 1'b1;
        steps(4);
        sw_in = 1'b0;
        do_reset();
        steps(12);
        chk("midrst_pend", {29'd0, pend_count}, 32'd0);
        chk("midrst_ovf", {31'd0, overflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
